// File: rtl/bf16_pkg.sv
// Shared types and constants for the bf16 sum-of-products engine and its arithmetic sub-units.
package bf16_pkg;
    localparam int          BF16_W    = 16;
    localparam int          BF16_SIGN = 15;
    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [2:0] {
        IDLE, CHECK, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE
    } state_e;
endpackage

// File: rtl/adder_bf16.sv
// bf16 adder behind an STB/BUSY handshake on both sides; round-to-nearest-even, denormals flush to zero.
module adder_bf16
    import bf16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BF16_W-1:0] a_i,
    input  logic [BF16_W-1:0] b_i,
    input  logic              stb_i,
    output logic              busy_o,
    output logic [BF16_W-1:0] z_o,
    output logic              stb_o,
    input  logic              busy_i
);
    logic [BF16_W-1:0] a_q, b_q, z_q;
    logic              busy_q, stb_q;

    function automatic logic [15:0] bf16_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0]       a, b;
        logic [7:0]        d, m;
        logic [4:0]        sh, lz;
        logic [31:0]       ma, mb, mbs, n;
        logic [32:0]       sum;
        logic signed [9:0] e;
        logic              g, st, found;
        if ((x[14:7] == 8'hFF && x[6:0] != 7'd0) || (y[14:7] == 8'hFF && y[6:0] != 7'd0)) return BF16_QNAN;
        // Order by magnitude so the larger operand sets sign and exponent.
        if (x[14:0] >= y[14:0]) begin
            a = x;
            b = y;
        end else begin
            a = y;
            b = x;
        end
        if (a[14:7] == 8'hFF) return (b[14:7] == 8'hFF && a[15] != b[15]) ? BF16_QNAN : a;
        if (b[14:7] == 8'd0) return (a[14:7] == 8'd0) ? {x[15] & y[15], 15'd0} : a;
        d   = a[14:7] - b[14:7];
        sh  = (d > 8'd31) ? 5'd31 : d[4:0];
        ma  = {1'b1, a[6:0], 24'd0};
        mb  = {1'b1, b[6:0], 24'd0};
        mbs = mb >> sh;
        mbs[0] = mbs[0] | ((mbs << sh) != mb);
        sum = (a[15] == b[15]) ? ({1'b0, ma} + {1'b0, mbs}) : ({1'b0, ma} - {1'b0, mbs});
        if (sum == 33'd0) return BF16_ZERO;
        e = $signed({2'b00, a[14:7]});
        if (sum[32]) begin
            n    = sum[32:1];
            n[0] = n[0] | sum[0];
            e    = e + 10'sd1;
        end else begin
            lz    = 5'd0;
            found = 1'b0;
            for (int k = 31; k >= 0; k--) begin
                if (!found) begin
                    if (sum[k]) found = 1'b1;
                    else        lz    = lz + 5'd1;
                end
            end
            n = sum[31:0] << lz;
            e = e - $signed({5'd0, lz});
        end
        m  = {1'b0, n[30:24]};
        g  = n[23];
        st = |n[22:0];
        m  = m + {7'd0, g & (st | m[0])};
        if (m[7]) begin
            m = 8'd0;
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) return {a[15], 8'hFF, 7'd0};
        if (e <= 10'sd0) return {a[15], 15'd0};
        return {a[15], e[7:0], m[6:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= BF16_ZERO;
            b_q    <= BF16_ZERO;
            z_q    <= BF16_ZERO;
            busy_q <= 1'b0;
            stb_q  <= 1'b0;
        end else if (!busy_q) begin
            if (stb_i) begin
                a_q    <= a_i;
                b_q    <= b_i;
                busy_q <= 1'b1;
            end
        end else if (!stb_q) begin
            z_q   <= bf16_add(a_q, b_q);
            stb_q <= 1'b1;
        end else if (!busy_i) begin
            stb_q  <= 1'b0;
            busy_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign z_o    = z_q;
    assign stb_o  = stb_q;
endmodule

// File: rtl/bf16_dot_product_lane_select.sv
// Picks lane idx from the flattened operand buses; negating operand a negates the product exactly.
module bf16_lane_select
    import bf16_pkg::*;
#(
    parameter int N_PAIRS = 8,
    parameter int IDX_W   = 4
) (
    input  logic [BF16_W*N_PAIRS-1:0] a_flat_i,
    input  logic [BF16_W*N_PAIRS-1:0] b_flat_i,
    input  logic [N_PAIRS-1:0]        neg_mask_i,
    input  logic [IDX_W-1:0]          idx_i,
    output logic [BF16_W-1:0]         a_o,
    output logic [BF16_W-1:0]         b_o
);
    always_comb begin
        a_o = BF16_ZERO;
        b_o = BF16_ZERO;
        for (int k = 0; k < N_PAIRS; k++) begin
            if (idx_i == IDX_W'(k)) begin
                a_o            = a_flat_i[k*BF16_W +: BF16_W];
                b_o            = b_flat_i[k*BF16_W +: BF16_W];
                a_o[BF16_SIGN] = a_o[BF16_SIGN] ^ neg_mask_i[k];
            end
        end
    end
endmodule

// File: rtl/multiplier_bf16.sv
// bf16 multiplier behind an STB/BUSY handshake on both sides; round-to-nearest-even, denormals flush to zero.
module multiplier_bf16
    import bf16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BF16_W-1:0] a_i,
    input  logic [BF16_W-1:0] b_i,
    input  logic              stb_i,
    output logic              busy_o,
    output logic [BF16_W-1:0] z_o,
    output logic              stb_o,
    input  logic              busy_i
);
    logic [BF16_W-1:0] a_q, b_q, z_q;
    logic              busy_q, stb_q;

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic              s, g, st;
        logic [7:0]        ea, eb, m;
        logic [15:0]       ma, mb, prod;
        logic signed [9:0] e;
        s  = a[15] ^ b[15];
        ea = a[14:7];
        eb = b[14:7];
        if ((ea == 8'hFF && a[6:0] != 7'd0) || (eb == 8'hFF && b[6:0] != 7'd0)) return BF16_QNAN;
        if (ea == 8'hFF || eb == 8'hFF) return (ea == 8'd0 || eb == 8'd0) ? BF16_QNAN : {s, 8'hFF, 7'd0};
        if (ea == 8'd0 || eb == 8'd0) return {s, 15'd0};
        ma   = {8'd0, 1'b1, a[6:0]};
        mb   = {8'd0, 1'b1, b[6:0]};
        prod = ma * mb;
        e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[15]) begin
            m  = {1'b0, prod[14:8]};
            g  = prod[7];
            st = |prod[6:0];
            e  = e + 10'sd1;
        end else begin
            m  = {1'b0, prod[13:7]};
            g  = prod[6];
            st = |prod[5:0];
        end
        m = m + {7'd0, g & (st | m[0])};
        if (m[7]) begin
            m = 8'd0;
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) return {s, 8'hFF, 7'd0};
        if (e <= 10'sd0) return {s, 15'd0};
        return {s, e[7:0], m[6:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= BF16_ZERO;
            b_q    <= BF16_ZERO;
            z_q    <= BF16_ZERO;
            busy_q <= 1'b0;
            stb_q  <= 1'b0;
        end else if (!busy_q) begin
            if (stb_i) begin
                a_q    <= a_i;
                b_q    <= b_i;
                busy_q <= 1'b1;
            end
        end else if (!stb_q) begin
            z_q   <= bf16_mul(a_q, b_q);
            stb_q <= 1'b1;
        end else if (!busy_i) begin
            stb_q  <= 1'b0;
            busy_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign z_o    = z_q;
    assign stb_o  = stb_q;
endmodule

// File: rtl/bf16_dot_product.sv
// bf16 sum of (+/-)a[i]*b[i] over a run-time lane count, sharing one multiplier and one adder.
module bf16_dot_product
    import bf16_pkg::*;
#(
    parameter int N_PAIRS = 8,
    parameter int LEN_W   = $clog2(N_PAIRS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BF16_W*N_PAIRS-1:0] input_a,
    input  logic [BF16_W*N_PAIRS-1:0] input_b,
    input  logic [LEN_W-1:0]          len,
    input  logic [N_PAIRS-1:0]        neg_mask,
    input  logic                      acc_mode,
    input  logic                      op_input_STB,
    output logic                      op_BUSY,
    output logic [BF16_W-1:0]         output_result,
    output logic                      op_output_STB,
    input  logic                      output_module_BUSY
);
    state_e                    state_q;
    logic [BF16_W*N_PAIRS-1:0] a_q, b_q;
    logic [N_PAIRS-1:0]        mask_q;
    logic [LEN_W-1:0]          len_q, i_q, len_d, i_d;
    logic                      acc_mode_q, busy_q, out_stb_q, mul_stb_q, add_stb_q;
    logic [BF16_W-1:0]         sum_q, acc_q, result_q, add_a_q, add_b_q;
    logic [BF16_W-1:0]         lane_a, lane_b, mul_z, add_z;
    logic                      mul_busy, mul_stb, add_busy, add_stb;

    assign len_d = (len > LEN_W'(N_PAIRS)) ? LEN_W'(N_PAIRS) : len;
    assign i_d   = i_q + LEN_W'(1);

    bf16_lane_select #(.N_PAIRS(N_PAIRS), .IDX_W(LEN_W)) u_lane (
        .a_flat_i   (a_q),
        .b_flat_i   (b_q),
        .neg_mask_i (mask_q),
        .idx_i      (i_q),
        .a_o        (lane_a),
        .b_o        (lane_b)
    );

    multiplier_bf16 u_mul (
        .clk    (clk),
        .rst    (rst),
        .a_i    (lane_a),
        .b_i    (lane_b),
        .stb_i  (mul_stb_q),
        .busy_o (mul_busy),
        .z_o    (mul_z),
        .stb_o  (mul_stb),
        .busy_i (state_q != MUL_WAIT)
    );

    adder_bf16 u_add (
        .clk    (clk),
        .rst    (rst),
        .a_i    (add_a_q),
        .b_i    (add_b_q),
        .stb_i  (add_stb_q),
        .busy_o (add_busy),
        .z_o    (add_z),
        .stb_o  (add_stb),
        .busy_i (state_q != ADD_WAIT)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            i_q        <= '0;
            acc_mode_q <= 1'b0;
            busy_q     <= 1'b0;
            out_stb_q  <= 1'b0;
            mul_stb_q  <= 1'b0;
            add_stb_q  <= 1'b0;
            sum_q      <= BF16_ZERO;
            acc_q      <= BF16_ZERO;
            result_q   <= BF16_ZERO;
            add_a_q    <= BF16_ZERO;
            add_b_q    <= BF16_ZERO;
        end else begin
            case (state_q)
                IDLE: if (op_input_STB) begin
                    a_q        <= input_a;
                    b_q        <= input_b;
                    mask_q     <= neg_mask;
                    len_q      <= len_d;
                    acc_mode_q <= acc_mode;
                    i_q        <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= CHECK;
                end
                CHECK: begin
                    if (len_q == '0) begin
                        sum_q   <= acc_mode_q ? acc_q : BF16_ZERO;
                        state_q <= DONE;
                    end else begin
                        state_q <= MUL_REQ;
                    end
                end
                MUL_REQ: begin
                    if (mul_stb_q && !mul_busy) begin
                        mul_stb_q <= 1'b0;
                        state_q   <= MUL_WAIT;
                    end else begin
                        mul_stb_q <= 1'b1;
                    end
                end
                // Fresh lane 0 bypasses the adder so a -0 product survives.
                MUL_WAIT: if (mul_stb) begin
                    if (i_q == '0 && !acc_mode_q) begin
                        sum_q   <= mul_z;
                        state_q <= NEXT;
                    end else begin
                        add_a_q <= (i_q == '0) ? acc_q : sum_q;
                        add_b_q <= mul_z;
                        state_q <= ADD_REQ;
                    end
                end
                ADD_REQ: begin
                    if (add_stb_q && !add_busy) begin
                        add_stb_q <= 1'b0;
                        state_q   <= ADD_WAIT;
                    end else begin
                        add_stb_q <= 1'b1;
                    end
                end
                ADD_WAIT: if (add_stb) begin
                    sum_q   <= add_z;
                    state_q <= NEXT;
                end
                NEXT: begin
                    i_q     <= i_d;
                    state_q <= (i_d == len_q) ? DONE : MUL_REQ;
                end
                DONE: begin
                    if (!out_stb_q) begin
                        out_stb_q <= 1'b1;
                        result_q  <= sum_q;
                        acc_q     <= sum_q;
                    end else if (!output_module_BUSY) begin
                        out_stb_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_BUSY       = busy_q;
    assign output_result = result_q;
    assign op_output_STB = out_stb_q;
endmodule

// File: tb/tb_bf16_dot_product.sv
// Directed bench for bf16_dot_product with hand-computed bf16 results.
module tb_bf16_dot_product;
    import bf16_pkg::*;

    localparam int N     = 8;
    localparam int LEN_W = $clog2(N + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [16*N-1:0]    input_a = '0;
    logic [16*N-1:0]    input_b = '0;
    logic [LEN_W-1:0]   len = '0;
    logic [N-1:0]       neg_mask = '0;
    logic               acc_mode = 1'b0;
    logic               op_input_STB = 1'b0;
    logic               op_BUSY;
    logic [15:0]        output_result;
    logic               op_output_STB;
    logic               output_module_BUSY = 1'b0;

    int checks = 0;
    int errors = 0;
    int mul_xfers = 0;
    int add_xfers = 0;
    int mul_base, add_base;

    bf16_dot_product #(.N_PAIRS(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_a            (input_a),
        .input_b            (input_b),
        .len                (len),
        .neg_mask           (neg_mask),
        .acc_mode           (acc_mode),
        .op_input_STB       (op_input_STB),
        .op_BUSY            (op_BUSY),
        .output_result      (output_result),
        .op_output_STB      (op_output_STB),
        .output_module_BUSY (output_module_BUSY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.mul_stb_q && !dut.mul_busy) mul_xfers <= mul_xfers + 1;
        if (dut.add_stb_q && !dut.add_busy) add_xfers <= add_xfers + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [LEN_W-1:0] l, input logic [N-1:0] m, input logic acc);
        @(negedge clk);
        len          = l;
        neg_mask     = m;
        acc_mode     = acc;
        op_input_STB = 1'b1;
        mul_base     = mul_xfers;
        add_base     = add_xfers;
        @(posedge clk);
        #1;
        op_input_STB = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (op_output_STB) break;
        end
        chk({tag, "_done"}, op_output_STB, 1);
    endtask

    task automatic run(input string tag, input logic [LEN_W-1:0] l, input logic [N-1:0] m,
                       input logic acc, input logic [15:0] exp, input int nm, input int na);
        send(l, m, acc);
        chk({tag, "_busy"}, op_BUSY, 1);
        wait_done(tag);
        chk({tag, "_result"}, output_result, exp);
        chk({tag, "_mul_xfers"}, mul_xfers - mul_base, nm);
        chk({tag, "_add_xfers"}, add_xfers - add_base, na);
        @(posedge clk);
        #1;
        chk({tag, "_stb_drop"}, op_output_STB, 0);
        chk({tag, "_busy_drop"}, op_BUSY, 0);
    endtask

    task automatic run_len0(input string tag, input logic acc, input logic [15:0] exp);
        send('0, '0, acc);
        @(posedge clk);
        #1;
        chk({tag, "_stb_early"}, op_output_STB, 0);
        @(posedge clk);
        #1;
        chk({tag, "_stb_2cyc"}, op_output_STB, 1);
        chk({tag, "_result"}, output_result, exp);
        chk({tag, "_mul_xfers"}, mul_xfers - mul_base, 0);
        chk({tag, "_add_xfers"}, add_xfers - add_base, 0);
        @(posedge clk);
        #1;
        chk({tag, "_busy_drop"}, op_BUSY, 0);
    endtask

    initial begin
        logic [15:0] ramp [8];
        ramp = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};

        #1;
        chk("rst_busy", op_BUSY, 0);
        chk("rst_stb", op_output_STB, 0);
        chk("rst_result", output_result, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1*2 + 3*4
        input_a[15:0] = 16'h3F80; input_a[31:16] = 16'h4040;
        input_b[15:0] = 16'h4000; input_b[31:16] = 16'h4080;
        run("fresh2", 2, 8'h00, 1'b0, 16'h4160, 2, 1);
        run("acc1", 1, 8'h00, 1'b1, 16'h4180, 1, 1);
        run("neg2", 2, 8'h02, 1'b0, 16'hC120, 2, 1);
        run_len0("len0_acc", 1'b1, 16'hC120);
        run_len0("len0_fresh", 1'b0, 16'h0000);

        input_a[15:0] = 16'h8000;
        input_b[15:0] = 16'h3F80;
        run("negzero", 1, 8'h00, 1'b0, 16'h8000, 1, 0);

        // Stall at DONE, with a command attempt that must be ignored.
        input_a[15:0] = 16'h3F80;
        input_b[15:0] = 16'h4000;
        output_module_BUSY = 1'b1;
        send(2, 8'h00, 1'b0);
        wait_done("stall");
        for (int c = 0; c < 10; c++) begin
            chk("stall_stb", op_output_STB, 1);
            chk("stall_result", output_result, 16'h4160);
            chk("stall_busy", op_BUSY, 1);
            op_input_STB = (c == 3);
            @(negedge clk);
        end
        op_input_STB = 1'b0;
        output_module_BUSY = 1'b0;
        @(posedge clk);
        #1;
        chk("release_stb", op_output_STB, 0);
        chk("release_busy", op_BUSY, 0);
        mul_base = mul_xfers;
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_cmd_busy", op_BUSY, 0);
        chk("ignored_cmd_mul", mul_xfers - mul_base, 0);

        // Abort in ADD_WAIT of lane 3.
        for (int k = 0; k < N; k++) begin
            input_a[k*16 +: 16] = 16'h3F80;
            input_b[k*16 +: 16] = ramp[k];
        end
        send(8, 8'h00, 1'b0);
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (dut.state_q == ADD_WAIT && dut.i_q == 3) break;
        end
        chk("reach_lane3_add", {31'd0, dut.state_q == ADD_WAIT && dut.i_q == 3}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", op_BUSY, 0);
        chk("abort_stb", op_output_STB, 0);
        chk("abort_result", output_result, 16'h0000);
        chk("abort_mul_stb", dut.u_mul.stb_o, 0);
        chk("abort_add_stb", dut.u_add.stb_o, 0);
        @(negedge clk);
        rst = 1'b0;

        run_len0("post_rst_acc", 1'b1, 16'h0000);
        run("fresh8", 8, 8'h00, 1'b0, 16'h4210, 8, 7);
        run("clamp15", 4'd15, 8'h00, 1'b1, 16'h4290, 8, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
